chameleon_cdtv_ir_tx: RTL and testbench



---
 rtl/chameleon_cdtv_ir_tx.sv | 130 +++++++++++++
 tb/tb_chameleon_cdtv_ir_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chameleon_cdtv_ir_tx.sv
// CDTV infrared remote transmitter: serialises a 12-bit code plus its complement into the
// active-low baseband IR waveform, with auto-repeat frames while hold is high.
module chameleon_cdtv_ir_tx #(
  parameter int unsigned LEADER_US        = 9000,
  parameter int unsigned LEADER_GAP_US    = 4500,
  parameter int unsigned REPEAT_GAP_US    = 2250,
  parameter int unsigned MARK_US          = 400,
  parameter int unsigned ZERO_SPACE_US    = 400,
  parameter int unsigned ONE_SPACE_US     = 1200,
  parameter int unsigned REPEAT_PERIOD_US = 60000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena_1mhz,
  input  logic [11:0] code,
  input  logic        send,
  input  logic        hold,
  output logic        busy,
  output logic        ir
);

  typedef enum logic [3:0] {
    StIdle, StLead, StLgap, StBmark, StBspace, StStop, StRwait, StRlead, StRgap, StRmark
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] dur_q, dur_d, phase_len;
  logic [16:0] per_q, per_d;
  logic [23:0] shreg_q, shreg_d;
  logic [4:0]  bit_q, bit_d;
  logic        phase_done, period_done;
  logic        ir_d, busy_d;

  always_comb begin
    unique case (state_q)
      StLead, StRlead: phase_len = 14'(LEADER_US);
      StLgap:          phase_len = 14'(LEADER_GAP_US);
      StRgap:          phase_len = 14'(REPEAT_GAP_US);
      StBspace:        phase_len = shreg_q[bit_q] ? 14'(ONE_SPACE_US) : 14'(ZERO_SPACE_US);
      default:         phase_len = 14'(MARK_US);
    endcase
  end

  // A phase of N ticks ends on the Nth tick after entry.
  assign phase_done  = ena_1mhz && (dur_q == phase_len - 14'd1);
  assign period_done = ena_1mhz && (per_q >= 17'(REPEAT_PERIOD_US - 1));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    per_d   = per_q;
    if (state_q != StIdle && ena_1mhz && per_q != '1) begin
      per_d = per_q + 17'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (send) begin
          shreg_d = {code, ~code};
          per_d   = '0;
          bit_d   = 5'd23;
          state_d = StLead;
        end
      end
      StLead: if (phase_done) state_d = StLgap;
      StLgap: begin
        if (phase_done) begin
          bit_d   = 5'd23;
          state_d = StBmark;
        end
      end
      StBmark: if (phase_done) state_d = StBspace;
      StBspace: begin
        if (phase_done) begin
          if (bit_q == 5'd0) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q - 5'd1;
            state_d = StBmark;
          end
        end
      end
      StStop, StRmark: if (phase_done) state_d = hold ? StRwait : StIdle;
      StRwait: begin
        if (!hold) begin
          state_d = StIdle;
        end else if (period_done) begin
          per_d   = '0;
          state_d = StRlead;
        end
      end
      StRlead: if (phase_done) state_d = StRgap;
      StRgap:  if (phase_done) state_d = StRmark;
      default: state_d = StIdle;
    endcase

    dur_d = dur_q;
    if (state_d != state_q || state_q == StIdle) begin
      dur_d = '0;
    end else if (ena_1mhz) begin
      dur_d = dur_q + 14'd1;
    end

    // Outputs are registered from the next state so they change on the transition edge.
    ir_d   = !(state_d inside {StLead, StBmark, StStop, StRlead, StRmark});
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      dur_q   <= '0;
      per_q   <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      ir      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      per_q   <= per_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      ir      <= ir_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_chameleon_cdtv_ir_tx.sv
// Directed bench for chameleon_cdtv_ir_tx using durations scaled down by ten so the run stays
// short; ena_1mhz is high every cycle except in the half-rate section.
module tb_chameleon_cdtv_ir_tx;

  localparam int unsigned Lead  = 900;
  localparam int unsigned Lgap  = 450;
  localparam int unsigned Rgap  = 225;
  localparam int unsigned Mark  = 40;
  localparam int unsigned Zero  = 40;
  localparam int unsigned One   = 120;
  localparam int unsigned Per   = 6000;
  localparam int          Bound = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ena_1mhz = 1'b1;
  logic [11:0] code = '0;
  logic        send = 1'b0;
  logic        hold = 1'b0;
  logic        busy, ir;
  logic        half_rate = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  chameleon_cdtv_ir_tx #(
    .LEADER_US(Lead), .LEADER_GAP_US(Lgap), .REPEAT_GAP_US(Rgap), .MARK_US(Mark),
    .ZERO_SPACE_US(Zero), .ONE_SPACE_US(One), .REPEAT_PERIOD_US(Per)
  ) dut (
    .clk(clk), .reset(reset), .ena_1mhz(ena_1mhz), .code(code),
    .send(send), .hold(hold), .busy(busy), .ir(ir)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      ena_1mhz = half_rate ? ~ena_1mhz : 1'b1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (ir === lvl && n < Bound) begin
      step(1);
      n++;
    end
  endtask

  // Leaves the bench one cycle into LEAD.
  task automatic start_frame(input logic [11:0] c);
    code = c;
    send = 1'b1;
    step(1);
    send = 1'b0;
  endtask

  task automatic rx_body(output logic [23:0] bits, output int bad, output int stop,
                         output int total);
    int m, s;
    bits  = '0;
    bad   = 0;
    total = 0;
    for (int i = 0; i < 24; i++) begin
      run_len(1'b0, m);
      run_len(1'b1, s);
      if (m != Mark) bad++;
      if (s != Zero && s != One) bad++;
      bits  = {bits[22:0], (s > 80)};
      total += m + s;
    end
    run_len(1'b0, stop);
    total += stop;
  endtask

  task automatic quiet(input int n, output int bad);
    bad = 0;
    repeat (n) begin
      step(1);
      if (ir !== 1'b1 || busy !== 1'b0) bad++;
    end
  endtask

  initial begin
    logic [23:0] bits;
    int lead, gap, bad, stop, total, t0, n;

    step(2);
    check("reset_ir", ir, 1);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    quiet(1000, bad);
    check("idle_quiet", bad, 0);

    // Code 0x000: twelve short spaces then twelve long ones.
    start_frame(12'h000);
    check("f0_busy_rise", busy, 1);
    run_len(1'b0, lead);
    run_len(1'b1, gap);
    check("f0_lead", lead, Lead);
    check("f0_lgap", gap, Lgap);
    rx_body(bits, bad, stop, total);
    check("f0_bits", bits, 24'h000FFF);
    check("f0_badlen", bad, 0);
    check("f0_stop", stop, Mark);
    check("f0_total", lead + gap + total, 4270);
    check("f0_busy_fall", busy, 0);
    check("f0_ir_idle", ir, 1);
    step(1);

    start_frame(12'hA5C);
    run_len(1'b0, lead);
    run_len(1'b1, gap);
    rx_body(bits, bad, stop, total);
    check("a5c_bits", bits, 24'hA5C5A3);
    check("a5c_badlen", bad, 0);
    check("a5c_busy_fall", busy, 0);
    step(1);

    // Auto-repeat: full frame, repeats at 6000 and 12000, hold released before the last mark.
    hold = 1'b1;
    start_frame(12'h123);
    t0 = cyc;
    run_len(1'b0, lead);
    run_len(1'b1, gap);
    rx_body(bits, bad, stop, total);
    check("rep_bits", bits, 24'h123EDC);
    check("rep_busy_rwait", busy, 1);
    run_len(1'b1, n);
    check("rep1_start", cyc - t0, Per);
    run_len(1'b0, lead);
    run_len(1'b1, gap);
    run_len(1'b0, stop);
    check("rep1_lead", lead, Lead);
    check("rep1_gap", gap, Rgap);
    check("rep1_mark", stop, Mark);
    run_len(1'b1, n);
    check("rep2_start", cyc - t0, 2 * Per);
    run_len(1'b0, lead);
    hold = 1'b0;
    run_len(1'b1, gap);
    run_len(1'b0, stop);
    check("rep2_gap", gap, Rgap);
    check("rep2_mark", stop, Mark);
    check("rep2_busy_fall", busy, 0);
    quiet(Per + 1000, bad);
    check("rep_no_third", bad, 0);

    // Hold dropping during RWAIT returns to idle on the next edge.
    hold = 1'b1;
    start_frame(12'h000);
    run_len(1'b0, lead);
    run_len(1'b1, gap);
    rx_body(bits, bad, stop, total);
    step(100);
    check("rwait_busy", busy, 1);
    hold = 1'b0;
    step(1);
    check("rwait_drop_busy", busy, 0);
    step(1);

    // A second send mid-frame with a different code must be ignored.
    start_frame(12'h3C6);
    step(500);
    code = 12'h999;
    send = 1'b1;
    step(1);
    send = 1'b0;
    run_len(1'b0, lead);
    check("mid_lead", lead + 501, Lead);
    run_len(1'b1, gap);
    rx_body(bits, bad, stop, total);
    check("mid_bits", bits, 24'h3C6C39);
    check("mid_badlen", bad, 0);
    quiet(2000, bad);
    check("mid_no_second", bad, 0);

    // Asynchronous reset in the middle of a frame.
    start_frame(12'h0FF);
    step(2000);
    check("rst_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("rst_async_ir", ir, 1);
    check("rst_async_busy", busy, 0);
    step(3);
    reset = 1'b0;
    quiet(50, bad);
    check("rst_quiet", bad, 0);
    start_frame(12'h0FF);
    run_len(1'b0, lead);
    run_len(1'b1, gap);
    rx_body(bits, bad, stop, total);
    check("rst_lead", lead, Lead);
    check("rst_bits", bits, 24'h0FFF00);
    check("rst_badlen", bad, 0);
    step(1);

    // Half-rate ticks: every phase after the first lasts exactly twice as many cycles.
    half_rate = 1'b1;
    step(4);
    start_frame(12'h000);
    run_len(1'b0, lead);
    run_len(1'b1, gap);
    run_len(1'b0, stop);
    check("half_lgap", gap, 2 * Lgap);
    check("half_mark", stop, 2 * Mark);
    n = 0;
    while (busy === 1'b1 && n < Bound) begin
      step(1);
      n++;
    end
    check("half_done", busy, 0);
    half_rate = 1'b0;
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
